dmem_arbiter: RTL and testbench

//  Shares the single Data_Memory port between the pipeline MEM stage (CPU port)
//  and an external loader/debug master (EXT port). Memory access is single-cycle:

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU priority, EXT preempts after MAX_WAIT denied cycles; CPU 0-cycle, EXT ack 1 cycle after grant.
// Backpressure via cpu_stall_o (CPU) and held ext_req_i until ext_ack_o (EXT); DMEM_ARB_STATS_EN adds stall/grant counters.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              ext_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_stall_cnt_o,
  output logic [15:0]       stat_ext_cnt_o
`endif
);

  localparam int WCNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WAIT_ONE = WCNT_W'(1);

  typedef enum logic [0:0] {
    ARB     = 1'b0,
    EXT_ACK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                ext_ack_q, ext_ack_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic                grant_ext;

  assign grant_ext = (state_q == ARB) && ext_req_i &&
                     (!cpu_req_i || (wait_cnt_q == WAIT_MAX));

  assign cpu_rdata_o = mem_rdata_i;
  assign cpu_stall_o = !rst_i && cpu_req_i && grant_ext;
  assign ext_ack_o   = ext_ack_q;
  assign ext_rdata_o = ext_rdata_q;

  // Reset gates the strobes combinationally so no write slips through mid-cycle.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    if (!rst_i) begin
      if (grant_ext) begin
        mem_addr_o  = ext_addr_i;
        mem_wdata_o = ext_wdata_i;
        mem_read_o  = !ext_we_i;
        mem_write_o = ext_we_i;
      end else if (cpu_req_i) begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_read_o  = !cpu_we_i;
        mem_write_o = cpu_we_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    ext_ack_d   = 1'b0;
    ext_rdata_d = ext_rdata_q;
    case (state_q)
      ARB: begin
        if (grant_ext) begin
          state_d     = EXT_ACK;
          ext_ack_d   = 1'b1;
          ext_rdata_d = mem_rdata_i;
          wait_cnt_d  = '0;
        end else if (!ext_req_i) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      EXT_ACK: begin
        // A still-asserted request here belongs to the access just acked.
        state_d = ARB;
        if (!ext_req_i) wait_cnt_d = '0;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB;
      wait_cnt_q  <= '0;
      ext_ack_q   <= 1'b0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ext_ack_q   <= ext_ack_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall_q, stat_stall_d;
  logic [15:0] stat_ext_q, stat_ext_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_ext_d   = stat_ext_q;
    if (cpu_stall_o && (stat_stall_q != 16'hFFFF)) stat_stall_d = stat_stall_q + 16'd1;
    if (grant_ext && (stat_ext_q != 16'hFFFF))     stat_ext_d   = stat_ext_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_stall_q <= '0;
      stat_ext_q   <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_ext_q   <= stat_ext_d;
    end
  end

  assign stat_stall_cnt_o = stat_stall_q;
  assign stat_ext_cnt_o   = stat_ext_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: MAX_WAIT=4 instance on a modelled data memory, plus a MAX_WAIT=0 instance.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] exp_v;

  // MAX_WAIT=4 instance signals
  logic          cpu_req, cpu_we, cpu_stall, ext_req, ext_we, ext_ack, mem_read, mem_write;
  logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, ext_wdata, ext_rdata, mem_wdata, mem_rdata;
  // MAX_WAIT=0 instance signals
  logic          cpu0_req, cpu0_we, cpu0_stall, ext0_req, ext0_we, ext0_ack, mem0_read, mem0_write;
  logic [AW-1:0] cpu0_addr, ext0_addr, mem0_addr;
  logic [DW-1:0] cpu0_wdata, cpu0_rdata, ext0_wdata, ext0_rdata, mem0_wdata, mem0_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_stall, stat_ext, stat0_stall, stat0_ext;
`endif

  assign mem_rdata  = mem[mem_addr[7:2]];
  assign mem0_rdata = 32'h0BAD_CAFE;
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_rdata_o(ext_rdata), .ext_ack_o(ext_ack),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_rdata_i(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_stall_cnt_o(stat_stall), .stat_ext_cnt_o(stat_ext)
`endif
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu0_req), .cpu_we_i(cpu0_we), .cpu_addr_i(cpu0_addr), .cpu_wdata_i(cpu0_wdata),
    .cpu_rdata_o(cpu0_rdata), .cpu_stall_o(cpu0_stall),
    .ext_req_i(ext0_req), .ext_we_i(ext0_we), .ext_addr_i(ext0_addr), .ext_wdata_i(ext0_wdata),
    .ext_rdata_o(ext0_rdata), .ext_ack_o(ext0_ack),
    .mem_addr_o(mem0_addr), .mem_wdata_o(mem0_wdata), .mem_read_o(mem0_read), .mem_write_o(mem0_write),
    .mem_rdata_i(mem0_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_stall_cnt_o(stat0_stall), .stat_ext_cnt_o(stat0_ext)
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ext_ack); end
    checks++; if (ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_ext_rdata: got %h want 0", ext_rdata); end
    @(negedge clk);
    cpu_req = 1'b0; ext_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_cpu_only();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL cpu_wr_strobe: got w=%b r=%b want w=1 r=0", mem_write, mem_read); end
    checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cpu_wr_fields: got %h/%h want 10/deadbeef", mem_addr, mem_wdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall: got %b want 0", cpu_stall); end
    @(negedge clk);
    cpu_we = 1'b0;
    exp_q.push_back(ref_mem[4]);
    #1;
    checks++; if (mem_read !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_strobe: got r=%b stall=%b want r=1 stall=0", mem_read, cpu_stall); end
    exp_v = exp_q.pop_front();
    checks++; if (cpu_rdata !== exp_v) begin errors++; $display("FAIL cpu_rd_data: got %h want %h", cpu_rdata, exp_v); end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL idle_bus: got r=%b w=%b a=%h want 0/0/0", mem_read, mem_write, mem_addr); end
  endtask

  task automatic test_ext_only();
    for (int i = 0; i < 2; i++) begin
      int lat;
      bit got;
      @(negedge clk);
      ext_req = 1'b1; ext_we = (i == 0); ext_addr = 32'h20; ext_wdata = 32'h1234_5678;
      if (i == 0) ref_mem[8] = 32'h1234_5678;
      else exp_q.push_back(ref_mem[8]);
      #1;
      checks++; if (mem_write !== (i == 0) || mem_read !== (i != 0) || mem_addr !== 32'h20) begin errors++; $display("FAIL ext_grant_%0d: got w=%b r=%b a=%h", i, mem_write, mem_read, mem_addr); end
      lat = 0; got = 1'b0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        lat++;
        if (ext_ack) begin got = 1'b1; break; end
      end
      ext_req = 1'b0;
      checks++; if (!got || lat != 1) begin errors++; $display("FAIL ext_ack_latency_%0d: got ack=%b after %0d cycles want 1 after 1", i, got, lat); end
      if (i == 1) begin
        exp_v = exp_q.pop_front();
        checks++; if (ext_rdata !== exp_v) begin errors++; $display("FAIL ext_rd_data: got %h want %h", ext_rdata, exp_v); end
      end
      @(negedge clk);
      checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL ext_ack_pulse_%0d: got %b want 0", i, ext_ack); end
    end
  endtask

  task automatic test_contention();
    exp_q.push_back(ref_mem[8]);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
      end
      #1;
      checks++; if (cpu_stall !== (c == 5)) begin errors++; $display("FAIL cont_stall_c%0d: got %b want %b", c, cpu_stall, (c == 5)); end
      checks++; if (ext_ack !== (c == 6)) begin errors++; $display("FAIL cont_ack_c%0d: got %b want %b", c, ext_ack, (c == 6)); end
      checks++; if (mem_addr !== ((c == 5) ? 32'h20 : 32'h10)) begin errors++; $display("FAIL cont_addr_c%0d: got %h", c, mem_addr); end
      if (c != 5) begin
        checks++; if (cpu_rdata !== ref_mem[4]) begin errors++; $display("FAIL cont_cpu_data_c%0d: got %h want %h", c, cpu_rdata, ref_mem[4]); end
      end
      if (c == 6) begin
        exp_v = exp_q.pop_front();
        checks++; if (ext_rdata !== exp_v) begin errors++; $display("FAIL cont_ext_data: got %h want %h", ext_rdata, exp_v); end
        ext_req = 1'b0;
      end
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
      end
      if (c == 1 || c == 7) exp_q.push_back(ref_mem[8]);
      #1;
      if (cpu_stall === 1'b1) stalls++;
      checks++; if (cpu_stall !== (c == 5 || c == 11)) begin errors++; $display("FAIL b2b_stall_c%0d: got %b", c, cpu_stall); end
      checks++; if (ext_ack !== (c == 6 || c == 12)) begin errors++; $display("FAIL b2b_ack_c%0d: got %b", c, ext_ack); end
      if (ext_ack === 1'b1 && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (ext_rdata !== exp_v) begin errors++; $display("FAIL b2b_ext_data_c%0d: got %h want %h", c, ext_rdata, exp_v); end
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; ext_req = 1'b0;
    checks++; if (stalls != 2) begin errors++; $display("FAIL b2b_stall_total: got %0d want 2", stalls); end
`ifdef DMEM_ARB_STATS_EN
    checks++; if (stat_stall !== 16'd2) begin errors++; $display("FAIL stat_stall_cnt: got %0d want 2", stat_stall); end
    checks++; if (stat_ext !== 16'd2) begin errors++; $display("FAIL stat_ext_cnt: got %0d want 2", stat_ext); end
`endif
    exp_q.delete();
  endtask

  task automatic test_max_wait0();
    int stalls;
    stalls = 0;
    exp_q.push_back(32'h0BAD_CAFE);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu0_req = 1'b1; cpu0_we = 1'b1; cpu0_addr = 32'h40; cpu0_wdata = 32'h1;
        ext0_req = 1'b1; ext0_we = 1'b0; ext0_addr = 32'h44;
      end
      #1;
      if (cpu0_stall === 1'b1) stalls++;
      if (c == 1) begin
        checks++; if (cpu0_stall !== 1'b1 || mem0_read !== 1'b1 || mem0_write !== 1'b0 || mem0_addr !== 32'h44) begin errors++; $display("FAIL mw0_first_grant: got stall=%b r=%b w=%b a=%h", cpu0_stall, mem0_read, mem0_write, mem0_addr); end
      end
      checks++; if (ext0_ack !== (c == 2)) begin errors++; $display("FAIL mw0_ack_c%0d: got %b want %b", c, ext0_ack, (c == 2)); end
      if (ext0_ack === 1'b1) begin
        exp_v = exp_q.pop_front();
        checks++; if (ext0_rdata !== exp_v) begin errors++; $display("FAIL mw0_ext_data: got %h want %h", ext0_rdata, exp_v); end
        ext0_req = 1'b0;
      end
    end
    cpu0_req = 1'b0; ext0_req = 1'b0;
    checks++; if (stalls != 1) begin errors++; $display("FAIL mw0_stall_once: got %0d want 1", stalls); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit got;
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre_write: got %b want 1", mem_write); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rstmid_async: got w=%b r=%b stall=%b want 0/0/0", mem_write, mem_read, cpu_stall); end
    @(negedge clk);
    ext_req = 1'b0; rst = 1'b0;
    #1;
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack: got %b want 0", ext_ack); end
    @(negedge clk);
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack_late: got %b want 0", ext_ack); end
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
    exp_q.push_back(ref_mem[8]);
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ext_ack) begin got = 1'b1; break; end
    end
    ext_req = 1'b0;
    checks++; if (!got) begin errors++; $display("FAIL rstmid_reissue_ack: got no ack within 8 cycles, want ack"); end
    exp_v = exp_q.pop_front();
    checks++; if (ext_rdata !== exp_v) begin errors++; $display("FAIL rstmid_mem_unchanged: got %h want %h", ext_rdata, exp_v); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    cpu0_req = 1'b0; cpu0_we = 1'b0; cpu0_addr = '0; cpu0_wdata = '0;
    ext0_req = 1'b0; ext0_we = 1'b0; ext0_addr = '0; ext0_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    test_reset();
    test_cpu_only();
    test_ext_only();
    test_contention();
    test_back_to_back();
    test_max_wait0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
